// File: rtl/gppcu_issue_queue.sv
// rtl/gppcu_issue_queue.sv - GPPCU instruction issue queue with register scoreboard
module gppcu_issue_queue #(
    parameter int DBW      = 32,
    parameter int QDEPTH   = 4,
    parameter int NUM_REG  = 32,
    parameter int RBW      = 5,
    parameter int REGD_LSB = 17,
    parameter int REGA_LSB = 12,
    parameter int REGB_LSB = 0,
    parameter int CNT_BW   = 16
) (
    input  logic              iACLK,
    input  logic              iRST,
    input  logic [DBW-1:0]    iINSTR,
    input  logic              iUSE_A,
    input  logic              iUSE_B,
    input  logic              iREG_WR,
    input  logic              iINSTR_VALID,
    output logic              oINSTR_READY,
    input  logic              iEXEC_BUSY,
    input  logic              iWB_VALID,
    input  logic [RBW-1:0]    iWB_REG,
    input  logic              iFLUSH,
    input  logic              iCNT_CLR,
    output logic              oISSUE_VALID,
    output logic [DBW-1:0]    oISSUE_INSTR,
    output logic              oISSUE_REG_WR,
    output logic              oSTALL_HAZARD,
    output logic [CNT_BW-1:0] oSTALL_CYCLES,
    output logic              oIDLING
);

    // Pointer width covers QDEPTH entries; count needs one extra bit so a
    // full queue is distinguishable from an empty one.
    localparam int PW        = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW        = PW + 1;
    localparam int NREG_FULL = 1 << RBW;

    // ------------------------------------------------------------------
    // FIFO storage and control state
    // ------------------------------------------------------------------
    logic [DBW-1:0]    fifo_instr_q [QDEPTH];
    logic              fifo_use_a_q [QDEPTH];
    logic              fifo_use_b_q [QDEPTH];
    logic              fifo_reg_wr_q[QDEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    // Scoreboard: one pending bit per architectural register
    logic [NUM_REG-1:0] pend_q, pend_d;

    // Issue-stage register
    logic              issue_valid_q, issue_valid_d;
    logic [DBW-1:0]    issue_instr_q, issue_instr_d;
    logic              issue_reg_wr_q, issue_reg_wr_d;

    // Stall counter
    logic [CNT_BW-1:0] stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Head-of-queue decode
    // ------------------------------------------------------------------
    logic              ready;
    logic              head_valid;
    logic [DBW-1:0]    head_instr;
    logic              head_use_a;
    logic              head_use_b;
    logic              head_reg_wr;
    logic [RBW-1:0]    head_rd;
    logic [RBW-1:0]    head_ra;
    logic [RBW-1:0]    head_rb;

    logic              push;
    logic              pop;
    logic              hazard;
    logic              issue;
    logic              stall_inc;

    assign ready       = (count_q != CW'(QDEPTH));
    assign head_valid  = (count_q != '0);
    assign head_instr  = fifo_instr_q[rd_ptr_q];
    assign head_use_a  = fifo_use_a_q[rd_ptr_q];
    assign head_use_b  = fifo_use_b_q[rd_ptr_q];
    assign head_reg_wr = fifo_reg_wr_q[rd_ptr_q];
    assign head_rd     = head_instr[REGD_LSB +: RBW];
    assign head_ra     = head_instr[REGA_LSB +: RBW];
    assign head_rb     = head_instr[REGB_LSB +: RBW];

    // ------------------------------------------------------------------
    // Effective pending view: a writeback this cycle already counts as
    // retired for hazard purposes. Indices beyond NUM_REG never block.
    // ------------------------------------------------------------------
    logic [NREG_FULL-1:0] pend_eff;

    for (genvar g = 0; g < NREG_FULL; g++) begin : g_pend_eff
        if (g < NUM_REG) begin : g_real
            assign pend_eff[g] = pend_q[g] & ~(iWB_VALID && (iWB_REG == RBW'(g)));
        end else begin : g_pad
            assign pend_eff[g] = 1'b0;
        end
    end

    // Head hazard: RAW on either source, WAW on the destination
    assign hazard = (head_use_a  & pend_eff[head_ra]) |
                    (head_use_b  & pend_eff[head_rb]) |
                    (head_reg_wr & pend_eff[head_rd]);

    // A push coinciding with a flush is discarded with the rest of the queue.
    assign push      = iINSTR_VALID & ready & ~iFLUSH;
    assign issue     = head_valid & ~hazard & ~iEXEC_BUSY & ~iFLUSH;
    assign pop       = issue;
    assign stall_inc = (head_valid & hazard) | (head_valid & iEXEC_BUSY);

    // ------------------------------------------------------------------
    // FIFO pointer and occupancy next-state
    // ------------------------------------------------------------------
    // Pointers advance on push/pop and wrap naturally at QDEPTH; flush empties.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state of the FIFO; reset drops every queued entry.
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is written at the tail on push; contents need no reset
    // because occupancy alone decides which entries are live.
    always_ff @(posedge iACLK) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q]  <= iINSTR;
            fifo_use_a_q[wr_ptr_q]  <= iUSE_A;
            fifo_use_b_q[wr_ptr_q]  <= iUSE_B;
            fifo_reg_wr_q[wr_ptr_q] <= iREG_WR;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next-state: writeback clears, issuing writer sets, and the
    // set is applied last so it wins when both hit the same register.
    // Flush leaves it alone because in-flight writers still retire.
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_REG; i++) begin
            if (iWB_VALID && (iWB_REG == RBW'(i))) begin
                pend_d[i] = 1'b0;
            end
            if (issue && head_reg_wr && (head_rd == RBW'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Issue stage: loads on issue, otherwise inserts a bubble while the
    // payload fields keep their previous contents.
    // ------------------------------------------------------------------
    always_comb begin
        issue_valid_d  = issue;
        issue_instr_d  = issue_instr_q;
        issue_reg_wr_d = issue_reg_wr_q;
        if (issue) begin
            issue_instr_d  = head_instr;
            issue_reg_wr_d = head_reg_wr;
        end
    end

    // Issue-stage register
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            issue_valid_q  <= 1'b0;
            issue_instr_q  <= '0;
            issue_reg_wr_q <= 1'b0;
        end else begin
            issue_valid_q  <= issue_valid_d;
            issue_instr_q  <= issue_instr_d;
            issue_reg_wr_q <= issue_reg_wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: clear beats increment, increment saturates at all-ones
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (iCNT_CLR) begin
            stall_cnt_d = '0;
        end else if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_BW'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oINSTR_READY  = ready;
    assign oISSUE_VALID  = issue_valid_q;
    assign oISSUE_INSTR  = issue_instr_q;
    assign oISSUE_REG_WR = issue_reg_wr_q;
    assign oSTALL_HAZARD = head_valid & hazard;
    assign oSTALL_CYCLES = stall_cnt_q;
    assign oIDLING       = ~head_valid & ~issue_valid_q & (pend_q == '0);

endmodule

// File: tb/tb_gppcu_issue_queue.sv
// tb/tb_gppcu_issue_queue.sv - directed scoreboard bench for gppcu_issue_queue
module tb_gppcu_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        use_a, use_b, reg_wr, instr_valid;
    logic        busy, wb_valid, flush, cnt_clr;
    logic [4:0]  wb_reg;

    logic        ready, issue_valid, issue_reg_wr, hazard, idling;
    logic [31:0] issue_instr;
    logic [15:0] stall_cycles;

    logic        s_ready, s_issue_valid, s_issue_reg_wr, s_hazard, s_idling;
    logic [31:0] s_issue_instr;
    logic [3:0]  s_stall_cycles;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;

    always #5 clk = ~clk;

    gppcu_issue_queue dut (
        .iACLK(clk), .iRST(rst), .iINSTR(instr), .iUSE_A(use_a), .iUSE_B(use_b),
        .iREG_WR(reg_wr), .iINSTR_VALID(instr_valid), .oINSTR_READY(ready),
        .iEXEC_BUSY(busy), .iWB_VALID(wb_valid), .iWB_REG(wb_reg), .iFLUSH(flush),
        .iCNT_CLR(cnt_clr), .oISSUE_VALID(issue_valid), .oISSUE_INSTR(issue_instr),
        .oISSUE_REG_WR(issue_reg_wr), .oSTALL_HAZARD(hazard),
        .oSTALL_CYCLES(stall_cycles), .oIDLING(idling)
    );

    gppcu_issue_queue #(.CNT_BW(4)) dut_small (
        .iACLK(clk), .iRST(rst), .iINSTR(instr), .iUSE_A(use_a), .iUSE_B(use_b),
        .iREG_WR(reg_wr), .iINSTR_VALID(instr_valid), .oINSTR_READY(s_ready),
        .iEXEC_BUSY(busy), .iWB_VALID(wb_valid), .iWB_REG(wb_reg), .iFLUSH(flush),
        .iCNT_CLR(cnt_clr), .oISSUE_VALID(s_issue_valid), .oISSUE_INSTR(s_issue_instr),
        .oISSUE_REG_WR(s_issue_reg_wr), .oSTALL_HAZARD(s_hazard),
        .oSTALL_CYCLES(s_stall_cycles), .oIDLING(s_idling)
    );

    function automatic logic [31:0] mk(input logic [7:0] tag, input logic [4:0] d,
                                       input logic [4:0] a, input logic [4:0] b);
        return {tag, 2'b00, d, a, 7'b0, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; every issued instruction is checked against the scoreboard.
    task automatic step();
        @(posedge clk);
        #1;
        if (issue_valid === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_issue: observed %0h expected none", issue_instr);
            end
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                chk("issue_instr", issue_instr, exp_e[31:0]);
                chk("issue_reg_wr", issue_reg_wr, exp_e[32]);
            end
        end
    endtask

    task automatic do_push(input logic [31:0] ins, input logic ua, input logic ub,
                           input logic wr, input logic add);
        instr = ins; use_a = ua; use_b = ub; reg_wr = wr; instr_valid = 1'b1;
        if (add) exp_q.push_back({wr, ins});
        step();
        instr_valid = 1'b0; use_a = 1'b0; use_b = 1'b0; reg_wr = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = '0; use_a = 0; use_b = 0; reg_wr = 0; instr_valid = 0;
        busy = 0; wb_valid = 0; wb_reg = '0; flush = 0; cnt_clr = 0;
        step(); step();
        chk("rst_valid", issue_valid, 0);
        chk("rst_instr", issue_instr, 0);
        chk("rst_reg_wr", issue_reg_wr, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_ready", ready, 1);
        chk("rst_idling", idling, 1);
        chk("rst_idling_small", s_idling, 1);
        rst = 1'b0;

        // Back-to-back independent stream: valid on edges 2..5 after first push
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                instr = mk(8'(8'h10 + k), 5'(k), 5'(k + 1), 5'(k + 2));
                instr_valid = 1'b1;
                exp_q.push_back({1'b0, instr});
            end else begin
                instr_valid = 1'b0;
            end
            step();
            chk("stream_valid", issue_valid, (k >= 1 && k <= 4));
        end

        // Fill while busy: ready drops after the 4th push, 5th is ignored
        busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_push(mk(8'(8'h20 + k), 5'd0, 5'd0, 5'd0), 0, 0, 0, 1);
            chk("fill_ready", ready, (k < 3));
        end
        do_push(mk(8'h24, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        chk("full_ready", ready, 0);
        chk("full_no_issue", issue_valid, 0);
        busy = 1'b0;
        repeat (5) step();
        chk("full_drained", exp_q.size(), 0);

        // RAW on r3, released by same-cycle writeback
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("raw_cnt_clr", stall_cycles, 0);
        do_push(mk(8'h30, 5'd3, 5'd0, 5'd0), 0, 0, 1, 1);
        do_push(mk(8'h31, 5'd0, 5'd3, 5'd0), 1, 0, 0, 1);
        chk("raw_writer_issued", issue_valid, 1);
        chk("raw_hazard", hazard, 1);
        repeat (3) step();
        chk("raw_hold_hazard", hazard, 1);
        chk("raw_hold_valid", issue_valid, 0);
        chk("raw_cnt", stall_cycles, 3);
        wb_valid = 1'b1; wb_reg = 5'd3; #1;
        chk("raw_bypass", hazard, 0);
        step();
        wb_valid = 1'b0;
        chk("raw_issue", issue_valid, 1);
        chk("raw_cnt_hold", stall_cycles, 3);
        step();
        chk("raw_idling", idling, 1);

        // WAW on r7; writeback and new writer on the same edge keeps r7 pending
        do_push(mk(8'h40, 5'd7, 5'd0, 5'd0), 0, 0, 1, 1);
        do_push(mk(8'h41, 5'd7, 5'd0, 5'd0), 0, 0, 1, 1);
        chk("waw_hazard", hazard, 1);
        step();
        chk("waw_hold_hazard", hazard, 1);
        chk("waw_hold_valid", issue_valid, 0);
        wb_valid = 1'b1; wb_reg = 5'd7;
        step();
        wb_valid = 1'b0;
        chk("waw_issue", issue_valid, 1);
        step();
        chk("waw_pend_kept", idling, 0);
        do_push(mk(8'h42, 5'd0, 5'd0, 5'd7), 0, 1, 0, 1);
        chk("waw_srcb_hazard", hazard, 1);
        wb_valid = 1'b1; wb_reg = 5'd7;
        step();
        wb_valid = 1'b0;
        chk("waw_srcb_issue", issue_valid, 1);
        step();
        chk("waw_idling", idling, 1);
        chk("waw_drained", exp_q.size(), 0);

        // Exec busy for 5 cycles with 2 queued
        busy = 1'b1;
        do_push(mk(8'h50, 5'd0, 5'd0, 5'd0), 0, 0, 0, 1);
        cnt_clr = 1'b1;
        do_push(mk(8'h51, 5'd0, 5'd0, 5'd0), 0, 0, 0, 1);
        cnt_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("busy_no_issue", issue_valid, 0);
        end
        chk("busy_cnt", stall_cycles, 5);
        chk("busy_cnt_small", s_stall_cycles, 5);
        busy = 1'b0;
        step(); step();
        chk("busy_cnt_after", stall_cycles, 5);
        chk("busy_drained", exp_q.size(), 0);

        // Flush with 3 queued and a simultaneous push; r9 stays pending
        do_push(mk(8'h60, 5'd9, 5'd0, 5'd0), 0, 0, 1, 1);
        step();
        busy = 1'b1;
        do_push(mk(8'h61, 5'd0, 5'd0, 5'd0), 0, 0, 0, 1);
        do_push(mk(8'h62, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        do_push(mk(8'h63, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        busy = 1'b0;
        do_push(mk(8'h64, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        chk("flush_pre_valid", issue_valid, 1);
        flush = 1'b1;
        do_push(mk(8'h65, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        flush = 1'b0;
        chk("flush_ready", ready, 1);
        chk("flush_valid", issue_valid, 0);
        chk("flush_pend_kept", idling, 0);
        wb_valid = 1'b1; wb_reg = 5'd9;
        step();
        wb_valid = 1'b0;
        chk("flush_empty_idling", idling, 1);
        step();
        chk("flush_drained", exp_q.size(), 0);

        // 20-cycle stall: 16-bit counter reads 20, 4-bit counter saturates
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        busy = 1'b1;
        do_push(mk(8'h70, 5'd0, 5'd0, 5'd0), 0, 0, 0, 1);
        repeat (20) step();
        chk("sat_cnt_wide", stall_cycles, 20);
        chk("sat_cnt_small", s_stall_cycles, 15);
        busy = 1'b0;
        step();
        chk("sat_drained", exp_q.size(), 0);

        // Reset mid-stream drops queued/staged state and the scoreboard
        do_push(mk(8'h80, 5'd12, 5'd0, 5'd0), 0, 0, 1, 1);
        do_push(mk(8'h81, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        busy = 1'b1;
        do_push(mk(8'h82, 5'd0, 5'd0, 5'd0), 0, 0, 0, 0);
        chk("pre_rst_cnt_nonzero", (stall_cycles != 0), 1);
        busy = 1'b0; rst = 1'b1;
        step();
        chk("mid_rst_valid", issue_valid, 0);
        chk("mid_rst_instr", issue_instr, 0);
        chk("mid_rst_reg_wr", issue_reg_wr, 0);
        chk("mid_rst_cnt", stall_cycles, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_idling", idling, 1);
        rst = 1'b0;
        step(); step();
        chk("post_rst_quiet", issue_valid, 0);
        do_push(mk(8'h90, 5'd12, 5'd0, 5'd0), 0, 0, 0, 1);
        step();
        chk("post_rst_issue", issue_valid, 1);
        step();
        chk("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
